rv_instr_encoder: RTL and testbench
===================================

// Module: rv_instr_encoder
// PURPOSE
//  Inverse of the RV32 decoder: turns a micro-op (op enum, rd, rs1, rs2, 32-bit imm) into a
//  32-bit RV32I instruction word for the subset the core decodes. Results go into a FIFO.
//  Each FIFO entry is tagged with a byte address. Feeds the boot/test-program loader that
//  writes instruction memory. Valid/ready on both sides.
// PARAMETERS
//  DEPTH      2   output FIFO entries (>=1)
//  ADDR_W     12  width of out_addr (byte address), wraps modulo 2^ADDR_W
//  BASE_ADDR  0   address tagged on first instruction after reset/restart (multiple of 4)
// PORTS
//  clk        in   1   clock
//  rst_n      in   1   async active-low reset
//  restart    in   1   sync: flush FIFO, address <- BASE_ADDR
//  in_valid   in   1   micro-op valid
//  in_ready   out  1   encoder can accept
//  in_op      in   5   0 ADD,1 SUB,2 XOR,3 OR,4 AND,5 ADDI,6 XORI,7 ORI,8 ANDI,9 SLLI,10 LB,
//                      11 LH,12 LW,13 LBU,14 LHU,15 SB,16 SH,17 SW,18 BEQ,19 BNE,20 BLT,21 BGE,
//                      22 BLTU,23 BGEU,24 LUI,25 AUIPC,26 JAL,27 JALR; 28-31 illegal
//  in_rd/in_rs1/in_rs2 in 5  register fields (unused fields ignored, encoded per format)
//  in_imm     in   32  immediate, signed; U-type: full value (imm[31:12] used)
//  out_valid  out  1   FIFO head valid
//  out_ready  in   1   consumer accepts head
//  out_instr  out  32  encoded instruction
//  out_addr   out  ADDR_W byte address of out_instr
//  err_illegal out 1   sticky: illegal op consumed
//  err_range  out  1   sticky: immediate out of range (IMM_CHECK_EN only, else tied 0)
//  clr_err    in   1   sync clear of both sticky flags
// BEHAVIOUR
//  - Reset: FIFO empty, out_valid=0, out_instr=0, out_addr=BASE_ADDR, err_*=0, in_ready=1.
//  - in_ready = !full && !restart. Accept on in_valid&&in_ready. Encode is combinational.
//    Push on the accept edge; out_valid rises the next cycle (latency 1). Pop on out_valid&&out_ready.
//  - Simultaneous push+pop when full is not allowed (in_ready=0 when full). Push+pop at other
//    occupancies: count unchanged, order preserved.
//  - Address counter advances +4 per push only, wrap 2^ADDR_W-4 -> 0. Tag stored with entry.
//  - Illegal op (28-31): consumed (in_ready handshake completes), not pushed, err_illegal<=1,
//    address not advanced.
//  - restart: FIFO emptied and address <- BASE_ADDR at the edge. It wins over push/pop that
//    cycle (no accept, popped entry is discarded). Sticky flags are unaffected.
//  - clr_err with a new error in the same cycle: the flag stays set (set wins).
//  - Formats: R (funct7[5]=1 only SUB), I/load/JALR imm[11:0], SLLI shamt=imm[4:0] funct7=0,
//    S imm[11:5]|[4:0], B imm[12|10:5|4:1|11], U imm[31:12], J imm[20|10:1|11|19:12].
//  - rst_n assert mid-operation: immediate async clear to reset values; contents are lost.
// CONFIGURATION
//  RV_ENC_IMM_CHECK_EN defined: range check before push. Limits:
//    - I/S: [-2048,2047]; SLLI: [0,31].
//    - B: [-4096,4094] and even; J: [-2^20, 2^20-2] and even; U: imm[11:0]==0.
//    On violation: consumed, not pushed, err_range<=1, address unchanged.
//  Undefined: no check. Low bits are truncated silently (B/J bit0 dropped). err_range=0.
// TESTING
//  ADDI rd=1 rs1=0 imm=5 -> out_instr=0x00500093, out_addr=0x000 one cycle after accept
//  ADD rd=3,rs1=1,rs2=2; SW rs1=1,rs2=2,imm=8 -> 0x002081B3@0x000, 0x0020A423@0x004
//  BEQ rs1=1,rs2=2,imm=-4 -> 0xFE208EE3; LUI rd=5 imm=0x12345000 -> 0x123452B7
//  out_ready=0, push DEPTH ops -> in_ready=0; out_ready=1 -> FIFO-order drain, addr +4 each
//  op=30 -> err_illegal=1, nothing pushed; clr_err -> 0; next op uses the unadvanced address
//  ADDI imm=4096: CHECK_EN -> err_range=1, no push; else 0x00000093; rst_n low when full -> out_valid=0

Source files
------------

// File: rtl/rv_instr_encoder_if.sv
// Valid/ready bus between a micro-op producer, the RV32I encoder and the
// instruction-memory loader that drains the encoder's output FIFO.
interface rv_instr_encoder_if #(
  parameter int ADDR_W = 12
);
  logic              in_valid;
  logic              in_ready;
  logic [4:0]        in_op;
  logic [4:0]        in_rd;
  logic [4:0]        in_rs1;
  logic [4:0]        in_rs2;
  logic [31:0]       in_imm;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_instr;
  logic [ADDR_W-1:0] out_addr;

  modport master (
    output in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, out_ready,
    input  in_ready, out_valid, out_instr, out_addr
  );

  modport slave (
    input  in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, out_ready,
    output in_ready, out_valid, out_instr, out_addr
  );
endinterface

// File: rtl/rv_instr_encoder.sv
// Micro-op to RV32I instruction encoder feeding an address-tagged output FIFO.
// Define RV_ENC_IMM_CHECK_EN to reject out-of-range immediates (err_range).
module rv_instr_encoder #(
  parameter int          DEPTH     = 2,
  parameter int          ADDR_W    = 12,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      restart,
  input  logic                      clr_err,
  output logic                      err_illegal,
  output logic                      err_range,
  rv_instr_encoder_if.slave         bus
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  localparam logic [4:0] OP_ADD  = 5'd0,  OP_SUB  = 5'd1,  OP_XOR  = 5'd2,  OP_OR   = 5'd3;
  localparam logic [4:0] OP_AND  = 5'd4,  OP_ADDI = 5'd5,  OP_XORI = 5'd6,  OP_ORI  = 5'd7;
  localparam logic [4:0] OP_ANDI = 5'd8,  OP_SLLI = 5'd9,  OP_LB   = 5'd10, OP_LH   = 5'd11;
  localparam logic [4:0] OP_LW   = 5'd12, OP_LBU  = 5'd13, OP_LHU  = 5'd14, OP_SB   = 5'd15;
  localparam logic [4:0] OP_SH   = 5'd16, OP_SW   = 5'd17, OP_BEQ  = 5'd18, OP_BNE  = 5'd19;
  localparam logic [4:0] OP_BLT  = 5'd20, OP_BGE  = 5'd21, OP_BLTU = 5'd22, OP_BGEU = 5'd23;
  localparam logic [4:0] OP_LUI  = 5'd24, OP_AUIPC = 5'd25, OP_JAL = 5'd26, OP_JALR  = 5'd27;

  function automatic logic [31:0] encode(input logic [4:0] op, input logic [4:0] rd,
                                         input logic [4:0] rs1, input logic [4:0] rs2,
                                         input logic [31:0] imm);
    logic [31:0] w;
    w = '0;
    case (op)
      OP_ADD:   w = {7'b0000000, rs2, rs1, 3'b000, rd, 7'b0110011};
      OP_SUB:   w = {7'b0100000, rs2, rs1, 3'b000, rd, 7'b0110011};
      OP_XOR:   w = {7'b0000000, rs2, rs1, 3'b100, rd, 7'b0110011};
      OP_OR:    w = {7'b0000000, rs2, rs1, 3'b110, rd, 7'b0110011};
      OP_AND:   w = {7'b0000000, rs2, rs1, 3'b111, rd, 7'b0110011};
      OP_ADDI:  w = {imm[11:0], rs1, 3'b000, rd, 7'b0010011};
      OP_XORI:  w = {imm[11:0], rs1, 3'b100, rd, 7'b0010011};
      OP_ORI:   w = {imm[11:0], rs1, 3'b110, rd, 7'b0010011};
      OP_ANDI:  w = {imm[11:0], rs1, 3'b111, rd, 7'b0010011};
      OP_SLLI:  w = {7'b0000000, imm[4:0], rs1, 3'b001, rd, 7'b0010011};
      OP_LB:    w = {imm[11:0], rs1, 3'b000, rd, 7'b0000011};
      OP_LH:    w = {imm[11:0], rs1, 3'b001, rd, 7'b0000011};
      OP_LW:    w = {imm[11:0], rs1, 3'b010, rd, 7'b0000011};
      OP_LBU:   w = {imm[11:0], rs1, 3'b100, rd, 7'b0000011};
      OP_LHU:   w = {imm[11:0], rs1, 3'b101, rd, 7'b0000011};
      OP_SB:    w = {imm[11:5], rs2, rs1, 3'b000, imm[4:0], 7'b0100011};
      OP_SH:    w = {imm[11:5], rs2, rs1, 3'b001, imm[4:0], 7'b0100011};
      OP_SW:    w = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
      OP_BEQ:   w = {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011};
      OP_BNE:   w = {imm[12], imm[10:5], rs2, rs1, 3'b001, imm[4:1], imm[11], 7'b1100011};
      OP_BLT:   w = {imm[12], imm[10:5], rs2, rs1, 3'b100, imm[4:1], imm[11], 7'b1100011};
      OP_BGE:   w = {imm[12], imm[10:5], rs2, rs1, 3'b101, imm[4:1], imm[11], 7'b1100011};
      OP_BLTU:  w = {imm[12], imm[10:5], rs2, rs1, 3'b110, imm[4:1], imm[11], 7'b1100011};
      OP_BGEU:  w = {imm[12], imm[10:5], rs2, rs1, 3'b111, imm[4:1], imm[11], 7'b1100011};
      OP_LUI:   w = {imm[31:12], rd, 7'b0110111};
      OP_AUIPC: w = {imm[31:12], rd, 7'b0010111};
      OP_JAL:   w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
      OP_JALR:  w = {imm[11:0], rs1, 3'b000, rd, 7'b1100111};
      default:  w = '0;
    endcase
    return w;
  endfunction

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  logic [CNT_W-1:0]  count;
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       instr_mem [DEPTH];
  logic [ADDR_W-1:0] addr_mem  [DEPTH];
  logic [31:0]       enc_p0;
  logic              accept, illegal, range_bad, push, pop;

  // Stage p0: combinational encode and accept decision
  assign enc_p0       = encode(bus.in_op, bus.in_rd, bus.in_rs1, bus.in_rs2, bus.in_imm);
  assign bus.in_ready = (count != CNT_W'(DEPTH)) && !restart;
  assign accept       = bus.in_valid && bus.in_ready;
  assign illegal      = (bus.in_op >= 5'd28);
  assign push         = accept && !illegal && !range_bad;
  assign pop          = bus.out_valid && bus.out_ready && !restart;

`ifdef RV_ENC_IMM_CHECK_EN
  function automatic logic imm_ok(input logic [4:0] op, input logic signed [31:0] imm);
    case (op)
      OP_ADDI, OP_XORI, OP_ORI, OP_ANDI, OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
      OP_SB, OP_SH, OP_SW, OP_JALR:
        return (imm >= -32'sd2048) && (imm <= 32'sd2047);
      OP_SLLI:
        return (imm >= 32'sd0) && (imm <= 32'sd31);
      OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU:
        return (imm >= -32'sd4096) && (imm <= 32'sd4094) && !imm[0];
      OP_JAL:
        return (imm >= -32'sd1048576) && (imm <= 32'sd1048574) && !imm[0];
      OP_LUI, OP_AUIPC:
        return (imm[11:0] == 12'h000);
      default:
        return 1'b1;
    endcase
  endfunction

  assign range_bad = !illegal && !imm_ok(bus.in_op, $signed(bus.in_imm));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_range <= 1'b0;
    else        err_range <= (accept && range_bad) || (err_range && !clr_err);
  end
`else
  assign range_bad = 1'b0;
  assign err_range = 1'b0;
`endif

  // Stage p1: FIFO state, address tagging and sticky error flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      addr        <= BASE;
      err_illegal <= 1'b0;
    end else begin
      if (restart) begin
        count  <= '0;
        wr_ptr <= '0;
        rd_ptr <= '0;
        addr   <= BASE;
      end else begin
        if (push) begin
          wr_ptr <= ptr_inc(wr_ptr);
          addr   <= addr + ADDR_W'(4);
        end
        if (pop) rd_ptr <= ptr_inc(rd_ptr);
        if (push && !pop)      count <= count + CNT_W'(1);
        else if (!push && pop) count <= count - CNT_W'(1);
      end
      err_illegal <= (accept && illegal) || (err_illegal && !clr_err);
    end
  end

  // Entry storage carries no reset; the head is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr] <= enc_p0;
      addr_mem[wr_ptr]  <= addr;
    end
  end

  assign bus.out_valid = (count != '0);
  assign bus.out_instr = bus.out_valid ? instr_mem[rd_ptr] : '0;
  assign bus.out_addr  = bus.out_valid ? addr_mem[rd_ptr] : addr;
endmodule

// File: tb/tb_rv_instr_encoder.sv
// Directed self-checking bench for rv_instr_encoder (default DEPTH=2, ADDR_W=12, BASE_ADDR=0).
module tb_rv_instr_encoder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic restart = 1'b0;
  logic clr_err = 1'b0;
  logic err_illegal, err_range;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [11:0] exp_addr;

  typedef struct packed {
    logic [4:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [31:0] exp;
  } vec_t;

  rv_instr_encoder_if #(.ADDR_W(12)) bus ();

  rv_instr_encoder dut (
    .clk(clk), .rst_n(rst_n), .restart(restart), .clr_err(clr_err),
    .err_illegal(err_illegal), .err_range(err_range), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic send(input logic [4:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [31:0] imm);
    bus.in_valid = 1'b1;
    bus.in_op = op; bus.in_rd = rd; bus.in_rs1 = rs1; bus.in_rs2 = rs2; bus.in_imm = imm;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic pop_one();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    n_cmp += 5;
    if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b want 0", bus.out_valid); end
    if (bus.out_instr !== 32'h0) begin n_bad++; $display("FAIL rst_instr: got %h want 0", bus.out_instr); end
    if (bus.out_addr !== 12'h000) begin n_bad++; $display("FAIL rst_addr: got %h want 000", bus.out_addr); end
    if ({err_illegal, err_range} !== 2'b00) begin n_bad++; $display("FAIL rst_err: got %b want 00", {err_illegal, err_range}); end
    if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_ready: got %b want 1", bus.in_ready); end
  endtask

  task automatic test_encode();
    vec_t v [15];
    v[0]  = '{5'd5,  5'd1, 5'd0, 5'd9, 32'd5,        32'h00500093}; // ADDI
    v[1]  = '{5'd0,  5'd3, 5'd1, 5'd2, 32'd0,        32'h002081B3}; // ADD
    v[2]  = '{5'd17, 5'd7, 5'd1, 5'd2, 32'd8,        32'h0020A423}; // SW
    v[3]  = '{5'd18, 5'd0, 5'd1, 5'd2, 32'hFFFFFFFC, 32'hFE208EE3}; // BEQ
    v[4]  = '{5'd24, 5'd5, 5'd0, 5'd0, 32'h12345000, 32'h123452B7}; // LUI
    v[5]  = '{5'd1,  5'd3, 5'd1, 5'd2, 32'd0,        32'h402081B3}; // SUB
    v[6]  = '{5'd9,  5'd2, 5'd2, 5'd0, 32'd3,        32'h00311113}; // SLLI
    v[7]  = '{5'd12, 5'd5, 5'd2, 5'd0, 32'hFFFFFFFC, 32'hFFC12283}; // LW
    v[8]  = '{5'd26, 5'd1, 5'd0, 5'd0, 32'd8,        32'h008000EF}; // JAL
    v[9]  = '{5'd27, 5'd0, 5'd1, 5'd0, 32'd0,        32'h00008067}; // JALR
    v[10] = '{5'd25, 5'd1, 5'd0, 5'd0, 32'h00001000, 32'h00001097}; // AUIPC
    v[11] = '{5'd19, 5'd0, 5'd3, 5'd0, 32'd16,       32'h00019863}; // BNE
    v[12] = '{5'd6,  5'd1, 5'd2, 5'd0, 32'hFFFFFFFF, 32'hFFF14093}; // XORI
    v[13] = '{5'd15, 5'd0, 5'd2, 5'd3, 32'hFFFFFFFF, 32'hFE310FA3}; // SB
    v[14] = '{5'd23, 5'd0, 5'd1, 5'd2, 32'd2048,     32'h0020F0E3}; // BGEU
    for (int i = 0; i < 15; i++) begin
      send(v[i].op, v[i].rd, v[i].rs1, v[i].rs2, v[i].imm);
      n_cmp += 3;
      if (bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL enc_valid_%0d: got %b want 1", i, bus.out_valid); end
      if (bus.out_instr !== v[i].exp) begin n_bad++; $display("FAIL enc_instr_%0d: got %h want %h", i, bus.out_instr, v[i].exp); end
      if (bus.out_addr !== exp_addr) begin n_bad++; $display("FAIL enc_addr_%0d: got %h want %h", i, bus.out_addr, exp_addr); end
      exp_addr += 12'd4;
      pop_one();
    end
  endtask

  task automatic test_fill_drain();
    logic [31:0] exp_i [2];
    logic [11:0] a0;
    exp_i[0] = 32'h00100093;
    exp_i[1] = 32'h00200093;
    a0 = exp_addr;
    send(5'd5, 5'd1, 5'd0, 5'd0, 32'd1);
    send(5'd5, 5'd1, 5'd0, 5'd0, 32'd2);
    exp_addr += 12'd8;
    n_cmp++;
    if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL full_ready: got %b want 0", bus.in_ready); end
    bus.out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      n_cmp += 2;
      if (bus.out_instr !== exp_i[i]) begin n_bad++; $display("FAIL drain_instr_%0d: got %h want %h", i, bus.out_instr, exp_i[i]); end
      if (bus.out_addr !== a0 + 12'(4 * i)) begin n_bad++; $display("FAIL drain_addr_%0d: got %h want %h", i, bus.out_addr, a0 + 12'(4 * i)); end
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b0;
    n_cmp++;
    if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL drain_empty: got %b want 0", bus.out_valid); end
  endtask

  task automatic test_illegal();
    send(5'd30, 5'd1, 5'd0, 5'd0, 32'd5);
    n_cmp += 2;
    if (err_illegal !== 1'b1) begin n_bad++; $display("FAIL ill_flag: got %b want 1", err_illegal); end
    if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL ill_nopush: got %b want 0", bus.out_valid); end
    clr_err = 1'b1;
    send(5'd31, 5'd1, 5'd0, 5'd0, 32'd5);
    clr_err = 1'b0;
    n_cmp++;
    if (err_illegal !== 1'b1) begin n_bad++; $display("FAIL ill_setwins: got %b want 1", err_illegal); end
    clr_err = 1'b1;
    @(posedge clk); #1;
    clr_err = 1'b0;
    n_cmp++;
    if (err_illegal !== 1'b0) begin n_bad++; $display("FAIL ill_clr: got %b want 0", err_illegal); end
    send(5'd5, 5'd1, 5'd0, 5'd0, 32'd5);
    n_cmp += 2;
    if (bus.out_instr !== 32'h00500093) begin n_bad++; $display("FAIL ill_next_instr: got %h want 00500093", bus.out_instr); end
    if (bus.out_addr !== exp_addr) begin n_bad++; $display("FAIL ill_next_addr: got %h want %h", bus.out_addr, exp_addr); end
    exp_addr += 12'd4;
    pop_one();
  endtask

  task automatic test_range();
    send(5'd5, 5'd1, 5'd0, 5'd0, 32'd4096);
`ifdef RV_ENC_IMM_CHECK_EN
    n_cmp += 2;
    if (err_range !== 1'b1) begin n_bad++; $display("FAIL rng_flag: got %b want 1", err_range); end
    if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL rng_nopush: got %b want 0", bus.out_valid); end
    clr_err = 1'b1;
    @(posedge clk); #1;
    clr_err = 1'b0;
    n_cmp++;
    if (err_range !== 1'b0) begin n_bad++; $display("FAIL rng_clr: got %b want 0", err_range); end
`else
    n_cmp += 3;
    if (bus.out_instr !== 32'h00000093) begin n_bad++; $display("FAIL rng_trunc: got %h want 00000093", bus.out_instr); end
    if (bus.out_addr !== exp_addr) begin n_bad++; $display("FAIL rng_addr: got %h want %h", bus.out_addr, exp_addr); end
    if (err_range !== 1'b0) begin n_bad++; $display("FAIL rng_flag: got %b want 0", err_range); end
    exp_addr += 12'd4;
    pop_one();
`endif
  endtask

  task automatic test_restart();
    send(5'd5, 5'd1, 5'd0, 5'd0, 32'd7);
    restart = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_op = 5'd5; bus.in_imm = 32'd9;
    bus.out_ready = 1'b1;
    #1;
    n_cmp++;
    if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL rs_ready: got %b want 0", bus.in_ready); end
    @(posedge clk); #1;
    restart = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    n_cmp++;
    if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL rs_empty: got %b want 0", bus.out_valid); end
    exp_addr = 12'h000;
    send(5'd5, 5'd1, 5'd0, 5'd0, 32'd5);
    n_cmp += 2;
    if (bus.out_instr !== 32'h00500093) begin n_bad++; $display("FAIL rs_instr: got %h want 00500093", bus.out_instr); end
    if (bus.out_addr !== 12'h000) begin n_bad++; $display("FAIL rs_addr: got %h want 000", bus.out_addr); end
    exp_addr += 12'd4;
    pop_one();
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_i [3];
    exp_i[0] = 32'h00100093;
    exp_i[1] = 32'h00200093;
    exp_i[2] = 32'h00300093;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bus.in_valid = 1'b1;
      bus.in_op = 5'd5; bus.in_rd = 5'd1; bus.in_rs1 = 5'd0; bus.in_rs2 = 5'd0;
      bus.in_imm = 32'(k + 1);
      @(posedge clk); #1;
      n_cmp += 3;
      if (bus.out_instr !== exp_i[k]) begin n_bad++; $display("FAIL b2b_instr_%0d: got %h want %h", k, bus.out_instr, exp_i[k]); end
      if (bus.out_addr !== exp_addr) begin n_bad++; $display("FAIL b2b_addr_%0d: got %h want %h", k, bus.out_addr, exp_addr); end
      if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready_%0d: got %b want 1", k, bus.in_ready); end
      exp_addr += 12'd4;
    end
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    n_cmp++;
    if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_empty: got %b want 0", bus.out_valid); end
  endtask

  task automatic test_async_reset();
    send(5'd5, 5'd1, 5'd0, 5'd0, 32'd1);
    send(5'd5, 5'd1, 5'd0, 5'd0, 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp += 4;
    if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL arst_valid: got %b want 0", bus.out_valid); end
    if (bus.out_instr !== 32'h0) begin n_bad++; $display("FAIL arst_instr: got %h want 0", bus.out_instr); end
    if (bus.out_addr !== 12'h000) begin n_bad++; $display("FAIL arst_addr: got %h want 000", bus.out_addr); end
    if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL arst_ready: got %b want 1", bus.in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.in_op = '0; bus.in_rd = '0; bus.in_rs1 = '0; bus.in_rs2 = '0; bus.in_imm = '0;
    exp_addr = 12'h000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_encode();
    test_fill_drain();
    test_illegal();
    test_range();
    test_restart();
    test_back_to_back();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
